// File: rtl/mant_align_shifter.sv
// Iterative right-shift mantissa aligner: one bit per clock with guard/sticky
// collection, valid/ready handshake on input and output.
module mant_align_shifter #(
    parameter int WIDTH = 12,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mant_in,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mant_out,
    output logic             guard,
    output logic             sticky,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Counter must hold WIDTH+1, the shift that empties the mantissa completely.
    localparam int CW = $clog2(WIDTH + 2);
    localparam int XW = (SHW > CW) ? SHW : CW;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [XW-1:0] SH_MAX  = XW'(WIDTH + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_init;
    logic [XW-1:0] sh_x;

    always_comb begin
        sh_x     = XW'(shamt);
        cnt_init = (sh_x > SH_MAX) ? CNT_MAX : CW'(sh_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = (cnt_init == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mant_out <= '0;
            guard    <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_out <= mant_in;
                        guard    <= 1'b0;
                        sticky   <= 1'b0;
                        cnt      <= cnt_init;
                    end
                end
                SHIFT: begin
                    // Previous guard bit folds into sticky as a new bit becomes guard.
                    mant_out <= {1'b0, mant_out[WIDTH-1:1]};
                    guard    <= mant_out[0];
                    sticky   <= sticky | guard;
                    cnt      <= cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);

endmodule

// File: tb/tb_mant_align_shifter.sv
// Self-checking bench for mant_align_shifter: arithmetic reference model with
// per-cycle compare, plus directed vectors with hand-computed results.
module tb_mant_align_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mant_in;
    logic [3:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] mant_out;
    logic        guard;
    logic        sticky;
    logic        busy;

    int tests = 0;
    int fails = 0;

    mant_align_shifter #(.WIDTH(12), .SHW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .guard     (guard),
        .sticky    (sticky),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from the shift identity on the clamped amount.
    task automatic model(input logic [11:0] m, input logic [3:0] s, output int n,
                         output logic [11:0] mo, output logic g, output logic st);
        int mi;
        n  = (s > 4'd13) ? 13 : int'(s);
        mi = int'(m);
        mo = 12'(mi >> n);
        g  = (n >= 1) ? (((mi >> (n - 1)) & 1) != 0) : 1'b0;
        st = (n >= 2) ? ((mi & ((1 << (n - 1)) - 1)) != 0) : 1'b0;
    endtask

    // Model state: edges since accept, and expected result of the in-flight op.
    bit          busy_m = 0;
    int          lat    = 0;
    int          n_m    = 0;
    logic [11:0] em     = '0;
    logic        eg     = 1'b0;
    logic        es     = 1'b0;
    bit          exp_ov;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_m = 0;
            chk("rst_mant_out", mant_out, 0);
            chk("rst_guard", guard, 0);
            chk("rst_sticky", sticky, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            if (busy_m) lat++;
            exp_ov = busy_m && (lat >= n_m + 1);
            chk("in_ready", in_ready, !busy_m);
            chk("busy", busy, busy_m);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("mant_out", mant_out, em);
                chk("guard", guard, eg);
                chk("sticky", sticky, es);
            end
            if (exp_ov && out_ready) begin
                busy_m = 0;
            end else if (!busy_m && in_valid) begin
                busy_m = 1;
                lat    = 0;
                model(mant_in, shamt, n_m, em, eg, es);
            end
        end
    end

    // Drives one operation; inputs change 1 time unit after the rising edge.
    task automatic run_op(input logic [11:0] m, input logic [3:0] s, input int stall,
                          input bit lit, input logic [11:0] xm, input logic xg,
                          input logic xs, input int xlat);
        int t;
        t = 0;
        while (!in_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
        mant_in   = m;
        shamt     = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        t = 0;
        while (!out_valid && t < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            mant_in  = 12'($urandom);
            shamt    = 4'($urandom);
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) begin
            chk("done_timeout", 0, 1);
        end else if (lit) begin
            chk("lit_latency", t, xlat);
            chk("lit_mant_out", mant_out, xm);
            chk("lit_guard", guard, xg);
            chk("lit_sticky", sticky, xs);
            chk("lit_in_ready_in_done", in_ready, 0);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = ~in_valid;
            mant_in  = 12'($urandom);
            shamt    = 4'($urandom);
            @(posedge clk); #1;
            if (lit) begin
                chk("lit_hold_mant", mant_out, xm);
                chk("lit_hold_valid", out_valid, 1);
            end
        end
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (lit) begin
            chk("lit_post_hs_valid", out_valid, 0);
            chk("lit_post_hs_ready", in_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_in   = '0;
        shamt     = '0;
        #1;
        chk("init_mant_out", mant_out, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(12'hABC, 4'd0,  0, 1, 12'hABC, 1'b0, 1'b0, 0);
        run_op(12'h801, 4'd3,  0, 1, 12'h100, 1'b0, 1'b1, 3);
        run_op(12'h800, 4'd12, 0, 1, 12'h000, 1'b1, 1'b0, 12);
        run_op(12'h001, 4'd15, 0, 1, 12'h000, 1'b0, 1'b1, 13);
        run_op(12'hFFF, 4'd14, 0, 1, 12'h000, 1'b0, 1'b1, 13);
        run_op(12'h0F0, 4'd4,  5, 1, 12'h00F, 1'b0, 1'b0, 4);
        run_op(12'h555, 4'd1,  0, 1, 12'h2AA, 1'b1, 1'b0, 1);

        // Asynchronous reset in the middle of a 10-bit shift.
        mant_in  = 12'hFFF;
        shamt    = 4'd10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_shift_mant", mant_out, 12'h0FF);
        chk("mid_shift_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mant", mant_out, 0);
        chk("async_rst_sticky", sticky, 0);
        chk("async_rst_guard", guard, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(12'h123, 4'd1, 0, 1, 12'h091, 1'b1, 1'b0, 1);

        for (int k = 0; k < 1000; k++) begin
            run_op(12'($urandom), 4'($urandom), $urandom_range(0, 3), 0, '0, 1'b0, 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
